gc_transmit: RTL and testbench

- Upstream stage of gc_receive. Drives the GameCube single-wire data line: sends the 24-bit poll command periodically, or the 8-bit probe/init command on request.
- Generates `send` (receiver hold-off) and `controller_init` (selects 24-bit ID capture vs 64-bit button capture) for gc_receive.
- Closes each transaction on the receiver's ready pulse or on a timeout.

---
 rtl/gc_pkg.sv | 22 ++
 rtl/gc_tx_bit.sv | 61 ++++++
 rtl/gc_transmit.sv | 171 +++++++++++++++++
 tb/tb_gc_transmit.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gc_pkg.sv
// rtl/gc_pkg.sv - shared constants and state type for the GameCube line transmitter
package gc_pkg;

  localparam logic [23:0] GC_POLL_CMD = 24'h400300;
  localparam logic [7:0]  GC_INIT_CMD = 8'h00;
  localparam int          GC_POLL_LEN = 24;
  localparam int          GC_INIT_LEN = 8;

  localparam int GC_Q_CYCLES     = 100;
  localparam int GC_POLL_PERIOD  = 1_600_000;
  localparam int GC_RESP_TIMEOUT = 50_000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_STOP_LOW,
    ST_STOP_HOLD,
    ST_WAIT_RESP
  } gc_tx_state_t;

endpackage

// File: rtl/gc_tx_bit.sv
// rtl/gc_tx_bit.sv - single-bit line encoder: low phase then released phase per bit slot
module gc_tx_bit
  import gc_pkg::*;
#(
  parameter int Q_CYCLES = GC_Q_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic bit_i,
  input  logic stop_i,
  output logic data_oe_o,
  output logic low_done_o,
  output logic bit_done_o
);

  localparam int CW = $clog2(4 * Q_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] low_end, slot_end;
  logic          active_q, active_d;
  logic          stop_q, stop_d;

  // The stop slot is half a bit long: one quarter low, one quarter released.
  always_comb begin
    low_end  = (stop_q || bit_i) ? CW'(Q_CYCLES - 1) : CW'(3 * Q_CYCLES - 1);
    slot_end = stop_q ? CW'(2 * Q_CYCLES - 1) : CW'(4 * Q_CYCLES - 1);
  end

  assign data_oe_o  = active_q && (cnt_q <= low_end);
  assign low_done_o = active_q && (cnt_q == low_end);
  assign bit_done_o = active_q && (cnt_q == slot_end);

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    stop_d   = stop_q;
    if (start_i) begin
      active_d = 1'b1;
      cnt_d    = '0;
      stop_d   = stop_i;
    end else if (bit_done_o) begin
      active_d = 1'b0;
    end else if (active_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      stop_q   <= stop_d;
    end
  end

endmodule

// File: rtl/gc_transmit.sv
// rtl/gc_transmit.sv - GameCube command transmitter: periodic poll, on-demand probe, response wait
module gc_transmit
  import gc_pkg::*;
#(
  parameter int          Q_CYCLES     = GC_Q_CYCLES,
  parameter logic [23:0] POLL_CMD     = GC_POLL_CMD,
  parameter logic [7:0]  INIT_CMD     = GC_INIT_CMD,
  parameter int          POLL_PERIOD  = GC_POLL_PERIOD,
  parameter int          RESP_TIMEOUT = GC_RESP_TIMEOUT
) (
  input  logic PCLK,
  input  logic PRESERN,
  input  logic start_init,
  input  logic wavebird_id_ready,
  input  logic button_data_ready,
  output logic data_oe,
  output logic send,
  output logic controller_init,
  output logic busy,
  output logic resp_timeout
);

  localparam int PW = $clog2(POLL_PERIOD + 1);
  localparam int TW = $clog2(RESP_TIMEOUT + 1);

  gc_tx_state_t  state_q, state_d;
  logic [23:0]   shift_q, shift_d;
  logic [4:0]    left_q, left_d;
  logic          init_mode_q, init_mode_d;
  logic          poll_pend_q, poll_pend_d;
  logic          init_pend_q, init_pend_d;
  logic [PW-1:0] ptmr_q, ptmr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          send_q, send_d;
  logic          cinit_q, cinit_d;
  logic          rto_q, rto_d;

  logic enc_start, enc_stop, enc_oe, enc_low_done, enc_bit_done;
  logic poll_wrap, resp_ready;

  gc_tx_bit #(.Q_CYCLES(Q_CYCLES)) u_bit (
    .clk_i      (PCLK),
    .rst_ni     (PRESERN),
    .start_i    (enc_start),
    .bit_i      (shift_q[23]),
    .stop_i     (enc_stop),
    .data_oe_o  (enc_oe),
    .low_done_o (enc_low_done),
    .bit_done_o (enc_bit_done)
  );

  assign poll_wrap  = (ptmr_q == PW'(POLL_PERIOD - 1));
  assign resp_ready = init_mode_q ? wavebird_id_ready : button_data_ready;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    left_d      = left_q;
    init_mode_d = init_mode_q;
    poll_pend_d = poll_pend_q;
    init_pend_d = init_pend_q;
    ptmr_d      = poll_wrap ? '0 : ptmr_q + 1'b1;
    tmo_d       = tmo_q;
    send_d      = send_q;
    cinit_d     = cinit_q;
    rto_d       = 1'b0;
    enc_start   = 1'b0;
    enc_stop    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (init_pend_q) begin
          shift_d     = {INIT_CMD, 16'h0000};
          left_d      = 5'(GC_INIT_LEN);
          init_mode_d = 1'b1;
          cinit_d     = 1'b1;
          init_pend_d = 1'b0;
        end else if (poll_pend_q) begin
          shift_d     = POLL_CMD;
          left_d      = 5'(GC_POLL_LEN);
          init_mode_d = 1'b0;
          poll_pend_d = 1'b0;
        end
        if (init_pend_q || poll_pend_q) begin
          enc_start = 1'b1;
          send_d    = 1'b1;
          state_d   = ST_BIT_LOW;
        end
      end
      ST_BIT_LOW: begin
        if (enc_low_done) state_d = ST_BIT_HIGH;
      end
      ST_BIT_HIGH: begin
        if (enc_bit_done) begin
          enc_start = 1'b1;
          if (left_q == 5'd1) begin
            enc_stop = 1'b1;
            state_d  = ST_STOP_LOW;
          end else begin
            shift_d = {shift_q[22:0], 1'b0};
            left_d  = left_q - 5'd1;
            state_d = ST_BIT_LOW;
          end
        end
      end
      ST_STOP_LOW: begin
        if (enc_low_done) state_d = ST_STOP_HOLD;
      end
      ST_STOP_HOLD: begin
        if (enc_bit_done) begin
          send_d  = 1'b0;
          tmo_d   = '0;
          state_d = ST_WAIT_RESP;
        end
      end
      ST_WAIT_RESP: begin
        // A ready pulse on the timeout cycle takes precedence over the timeout.
        if (resp_ready) begin
          cinit_d = 1'b0;
          state_d = ST_IDLE;
        end else if (tmo_q == TW'(RESP_TIMEOUT - 1)) begin
          rto_d   = 1'b1;
          cinit_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Requests arriving on a load cycle must survive the clear above.
    if (start_init) init_pend_d = 1'b1;
    if (poll_wrap)  poll_pend_d = 1'b1;
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      left_q      <= '0;
      init_mode_q <= 1'b0;
      poll_pend_q <= 1'b0;
      init_pend_q <= 1'b0;
      ptmr_q      <= '0;
      tmo_q       <= '0;
      send_q      <= 1'b0;
      cinit_q     <= 1'b0;
      rto_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      left_q      <= left_d;
      init_mode_q <= init_mode_d;
      poll_pend_q <= poll_pend_d;
      init_pend_q <= init_pend_d;
      ptmr_q      <= ptmr_d;
      tmo_q       <= tmo_d;
      send_q      <= send_d;
      cinit_q     <= cinit_d;
      rto_q       <= rto_d;
    end
  end

  assign data_oe         = enc_oe;
  assign send            = send_q;
  assign controller_init = cinit_q;
  assign busy            = (state_q != ST_IDLE);
  assign resp_timeout    = rto_q;

endmodule

// File: tb/tb_gc_transmit.sv
// tb/tb_gc_transmit.sv - directed self-checking bench for gc_transmit
module tb_gc_transmit;

  localparam int Q  = 10;
  localparam int PP = 2000;
  localparam int RT = 500;
  localparam logic [23:0] POLL = 24'h400300;
  localparam logic [23:0] INIT = 24'h000000;

  logic PCLK = 1'b0;
  logic PRESERN, start_init, wavebird_id_ready, button_data_ready;
  logic data_oe, send, controller_init, busy, resp_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  logic cap [0:1023];

  gc_transmit #(
    .Q_CYCLES(Q), .POLL_CMD(POLL), .INIT_CMD(INIT[7:0]),
    .POLL_PERIOD(PP), .RESP_TIMEOUT(RT)
  ) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .start_init(start_init),
    .wavebird_id_ready(wavebird_id_ready), .button_data_ready(button_data_ready),
    .data_oe(data_oe), .send(send), .controller_init(controller_init),
    .busy(busy), .resp_timeout(resp_timeout)
  );

  always #5 PCLK = ~PCLK;

  task automatic do_reset();
    PRESERN = 1'b0;
    start_init = 1'b0; wavebird_id_ready = 1'b0; button_data_ready = 1'b0;
    repeat (3) @(negedge PCLK);
    PRESERN = 1'b1;
  endtask

  task automatic pulse_start();
    start_init = 1'b1;
    @(negedge PCLK);
    start_init = 1'b0;
  endtask

  // Returns the index of the first post-reset sample with data_oe high (0 = first cycle).
  task automatic wait_oe(output int idx);
    idx = -1;
    do begin
      @(negedge PCLK);
      idx++;
    end while (!data_oe && idx < 3000);
  endtask

  task automatic capture_tx(output int len);
    len = 0;
    while (send && len < 1024) begin
      cap[len] = data_oe;
      len++;
      @(negedge PCLK);
    end
  endtask

  task automatic wait_send_low(input string name);
    int k = 0;
    while (send && k < 2000) begin
      @(negedge PCLK);
      k++;
    end
    n_tests++;
    if (send !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_send_fall: send=%b still high after %0d cycles, required 0", name, send, k);
    end
  endtask

  task automatic check_wave(input string name, input logic [23:0] cmd, input int nbits, input int len);
    int exp_len, bad, off, idx;
    logic b, e;
    logic [23:0] dec;
    exp_len = (nbits * 4 + 2) * Q;
    n_tests++;
    if (len !== exp_len) begin
      n_fail++;
      $display("FAIL %s_send_len: got %0d cycles, required %0d", name, len, exp_len);
    end
    bad = 0;
    for (int n = 0; n < exp_len && n < len; n++) begin
      if (n < nbits * 4 * Q) begin
        b   = cmd[nbits - 1 - n / (4 * Q)];
        off = n % (4 * Q);
        e   = (off < (b ? Q : 3 * Q));
      end else begin
        off = n - nbits * 4 * Q;
        e   = (off < Q);
      end
      if (cap[n] !== e) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s_waveform: %0d samples differ, required 0", name, bad);
    end
    dec = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = i * 4 * Q + 2 * Q;
      dec = {dec[22:0], (idx < 1024) ? ~cap[idx] : 1'b0};
    end
    n_tests++;
    if (dec !== cmd) begin
      n_fail++;
      $display("FAIL %s_decode: got %h, required %h", name, dec, cmd);
    end
  endtask

  task automatic test_reset();
    PRESERN = 1'b0;
    start_init = 1'b0; wavebird_id_ready = 1'b0; button_data_ready = 1'b0;
    repeat (3) @(negedge PCLK);
    n_tests++;
    if ({data_oe, send, controller_init, busy, resp_timeout} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got oe/send/ci/busy/rto=%b, required 00000",
               {data_oe, send, controller_init, busy, resp_timeout});
    end
  endtask

  task automatic test_poll();
    int idx, len;
    do_reset();
    wait_oe(idx);
    n_tests++;
    if (idx != PP) begin
      n_fail++;
      $display("FAIL poll_start_cycle: got %0d, required %0d", idx, PP);
    end
    n_tests++;
    if ({send, busy, controller_init} !== 3'b110) begin
      n_fail++;
      $display("FAIL poll_load_flags: send/busy/ci=%b, required 110", {send, busy, controller_init});
    end
    capture_tx(len);
    check_wave("poll", POLL, 24, len);
    wavebird_id_ready = 1'b1;
    @(negedge PCLK);
    wavebird_id_ready = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL poll_wrong_ready: busy=%b, required 1", busy);
    end
    button_data_ready = 1'b1;
    @(negedge PCLK);
    button_data_ready = 1'b0;
    n_tests++;
    if ({busy, resp_timeout} !== 2'b00) begin
      n_fail++;
      $display("FAIL poll_close: busy/rto=%b, required 00", {busy, resp_timeout});
    end
  endtask

  task automatic test_init();
    int len;
    do_reset();
    repeat (5) @(negedge PCLK);
    pulse_start();
    n_tests++;
    if (data_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL init_oe_early: data_oe=%b, required 0", data_oe);
    end
    @(negedge PCLK);
    n_tests++;
    if ({data_oe, controller_init, send} !== 3'b111) begin
      n_fail++;
      $display("FAIL init_start: oe/ci/send=%b, required 111", {data_oe, controller_init, send});
    end
    capture_tx(len);
    check_wave("init", INIT, 8, len);
    button_data_ready = 1'b1;
    @(negedge PCLK);
    button_data_ready = 1'b0;
    n_tests++;
    if ({busy, controller_init} !== 2'b11) begin
      n_fail++;
      $display("FAIL init_wrong_ready: busy/ci=%b, required 11", {busy, controller_init});
    end
    wavebird_id_ready = 1'b1;
    @(negedge PCLK);
    wavebird_id_ready = 1'b0;
    n_tests++;
    if ({busy, controller_init} !== 2'b00) begin
      n_fail++;
      $display("FAIL init_close: busy/ci=%b, required 00", {busy, controller_init});
    end
  endtask

  task automatic test_timeout();
    int cnt_at = -1;
    int pulses = 0;
    logic [1:0] flags_at = 2'b11;
    do_reset();
    repeat (5) @(negedge PCLK);
    pulse_start();
    @(negedge PCLK);
    wait_send_low("timeout");
    button_data_ready = 1'b1;
    for (int c = 1; c <= RT + 50; c++) begin
      @(negedge PCLK);
      button_data_ready = 1'b0;
      if (resp_timeout) begin
        pulses++;
        if (cnt_at < 0) begin
          cnt_at   = c;
          flags_at = {busy, controller_init};
        end
      end
    end
    n_tests++;
    if (cnt_at != RT) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d cycles, required %0d", cnt_at, RT);
    end
    n_tests++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL timeout_pulses: got %0d, required 1", pulses);
    end
    n_tests++;
    if (flags_at !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout_close: busy/ci=%b, required 00", flags_at);
    end
  endtask

  task automatic test_tie();
    int len, busy_seen = 0;
    do_reset();
    repeat (1999) @(negedge PCLK);
    pulse_start();
    @(negedge PCLK);
    n_tests++;
    if ({data_oe, controller_init} !== 2'b11) begin
      n_fail++;
      $display("FAIL tie_init_first: oe/ci=%b, required 11", {data_oe, controller_init});
    end
    capture_tx(len);
    check_wave("tie_init", INIT, 8, len);
    wavebird_id_ready = 1'b1;
    @(negedge PCLK);
    wavebird_id_ready = 1'b0;
    @(negedge PCLK);
    n_tests++;
    if ({data_oe, send, controller_init} !== 3'b110) begin
      n_fail++;
      $display("FAIL tie_poll_follows: oe/send/ci=%b, required 110", {data_oe, send, controller_init});
    end
    capture_tx(len);
    check_wave("tie_poll", POLL, 24, len);
    button_data_ready = 1'b1;
    @(negedge PCLK);
    button_data_ready = 1'b0;
    repeat (300) begin
      @(negedge PCLK);
      if (busy) busy_seen++;
    end
    n_tests++;
    if (busy_seen != 0) begin
      n_fail++;
      $display("FAIL tie_single_poll: busy for %0d cycles, required 0", busy_seen);
    end
  endtask

  task automatic test_reset_mid();
    int idx;
    do_reset();
    wait_oe(idx);
    @(posedge PCLK);
    #2;
    n_tests++;
    if (data_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_pre_oe: data_oe=%b, required 1", data_oe);
    end
    PRESERN = 1'b0;
    #1;
    n_tests++;
    if ({data_oe, send, controller_init} !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_async: oe/send/ci=%b, required 000", {data_oe, send, controller_init});
    end
    @(negedge PCLK);
    PRESERN = 1'b1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_idle: busy=%b, required 0", busy);
    end
    wait_oe(idx);
    n_tests++;
    if (idx != PP) begin
      n_fail++;
      $display("FAIL midreset_timer_restart: poll at %0d, required %0d", idx, PP);
    end
  endtask

  task automatic test_multi_init();
    int idx, ci_seen = 0;
    do_reset();
    wait_oe(idx);
    repeat (100) @(negedge PCLK);
    pulse_start();
    repeat (100) @(negedge PCLK);
    pulse_start();
    repeat (100) @(negedge PCLK);
    pulse_start();
    wait_send_low("multi_poll");
    n_tests++;
    if (controller_init !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_poll_mode: ci=%b, required 0", controller_init);
    end
    button_data_ready = 1'b1;
    @(negedge PCLK);
    button_data_ready = 1'b0;
    @(negedge PCLK);
    n_tests++;
    if ({data_oe, controller_init} !== 2'b11) begin
      n_fail++;
      $display("FAIL multi_init_follows: oe/ci=%b, required 11", {data_oe, controller_init});
    end
    wait_send_low("multi_init");
    wavebird_id_ready = 1'b1;
    @(negedge PCLK);
    wavebird_id_ready = 1'b0;
    repeat (300) begin
      @(negedge PCLK);
      if (busy || controller_init) ci_seen++;
    end
    n_tests++;
    if (ci_seen != 0) begin
      n_fail++;
      $display("FAIL multi_single_init: extra activity for %0d cycles, required 0", ci_seen);
    end
  endtask

  initial begin
    test_reset();
    test_poll();
    test_init();
    test_timeout();
    test_tie();
    test_reset_mid();
    test_multi_init();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
